// File: rtl/line_mem_responder.sv
// Single-outstanding line memory responder: fixed-latency read/write of whole cache lines
// against an internal backing store, with response handshake and completion counters.
module line_mem_responder #(
   parameter int unsigned LINE_SIZE  = 128,
   parameter int unsigned ADDR_LEN   = 27,
   parameter int unsigned OFFSET_LEN = 2,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_en,
   output logic                 req_rdy,
   input  logic                 req_cmd,
   input  logic [ADDR_LEN-1:0]  req_addr,
   input  logic [LINE_SIZE-1:0] req_data,
   output logic                 rsp_en,
   input  logic                 rsp_rdy,
   output logic [LINE_SIZE-1:0] rsp_data,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [7:0] LatLoad = 8'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                r_state;
   logic [7:0]            r_cnt;
   logic                  r_cmd;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic                  r_rsp_en;
   logic [LINE_SIZE-1:0]  r_rsp_data;
   logic [15:0]           r_rd_count;
   logic [15:0]           r_wr_count;
   logic [LINE_SIZE-1:0]  r_mem [Depth];

   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_accept;
   logic                  w_unused_addr;

   // Upper address bits alias onto the same line; only the index field is decoded.
   assign w_idx         = req_addr[OFFSET_LEN +: DEPTH_LOG2];
   assign w_unused_addr = ^req_addr;
   assign w_accept      = req_en && (r_state == StIdle) && !rst;

   assign req_rdy  = (r_state == StIdle);
   assign rsp_en   = r_rsp_en;
   assign rsp_data = r_rsp_data;
   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

   // Backing store is deliberately not reset; writes commit at acceptance.
   always_ff @(posedge clk) begin
      if (w_accept && !req_cmd) begin
         r_mem[w_idx] <= req_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_cnt      <= 8'd0;
         r_cmd      <= 1'b0;
         r_idx      <= '0;
         r_rsp_en   <= 1'b0;
         r_rsp_data <= '0;
         r_rd_count <= 16'd0;
         r_wr_count <= 16'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (req_en) begin
                  r_state <= StBusy;
                  r_cnt   <= LatLoad;
                  r_cmd   <= req_cmd;
                  r_idx   <= w_idx;
               end
            end
            StBusy: begin
               if (r_cnt == 8'd0) begin
                  r_state    <= StResp;
                  r_rsp_en   <= 1'b1;
                  r_rsp_data <= r_cmd ? r_mem[r_idx] : '0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            StResp: begin
               if (rsp_rdy) begin
                  r_state    <= StIdle;
                  r_rsp_en   <= 1'b0;
                  r_rsp_data <= '0;
                  if (r_cmd) begin
                     r_rd_count <= r_rd_count + 16'd1;
                  end else begin
                     r_wr_count <= r_wr_count + 16'd1;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
